// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: state codes, ACK levels,
// default device address and the address-compare helper.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WR_PTR    = 3'd3;
    localparam logic [2:0] ST_WR_BYTE   = 3'd4;
    localparam logic [2:0] ST_RD_BYTE   = 3'd5;
    localparam logic [2:0] ST_RD_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] I2C_DEFAULT_ADDR     = 7'h2C;
    localparam int         I2C_DEFAULT_FILT_LEN = 3;

    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Byte-wide register-file port of the I2C target: write strobe/address/data
// and a pointer-addressed combinational read.
interface i2c_target_if;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_strobe;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, rd_strobe,
                    input  rd_data);
    modport slave  (input  wr_en, wr_addr, wr_data, rd_addr, rd_strobe,
                    output rd_data);
endinterface

// File: rtl/i2c_line_filter.sv
// One pad input: 2-FF synchronizer, then a level is accepted only after
// FILT_LEN identical samples; single-cycle rise/fall flags follow the level.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_in,
    input  logic rst,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [FILT_LEN-1:0] hist_q, hist_d;
    logic                filt_q, filt_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;

    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
        hist_d  = (hist_q << 1) | FILT_LEN'(sync2_q);
        filt_d  = filt_q;
        if (&hist_q) begin
            filt_d = 1'b1;
        end else if (~|hist_q) begin
            filt_d = 1'b0;
        end
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;
    end

    // Idle bus is high, so everything presets to 1 to avoid a fake edge out of reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '1;
            filt_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = filt_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address, pointer byte, auto-incrementing burst
// write/read and repeated START, fronting a byte-wide register file.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = I2C_DEFAULT_ADDR,
    parameter int         FILT_LEN = I2C_DEFAULT_FILT_LEN
) (
    input  logic        clk_in,
    input  logic        RST,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        busy,
    i2c_target_if.master rf
);
    logic [1:0] pin_raw, pin_lvl, pin_rise, pin_fall;

    assign pin_raw = {sda_in, scl_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .clk_in (clk_in),
            .rst    (RST),
            .pin_in (pin_raw[gi]),
            .level  (pin_lvl[gi]),
            .rise   (pin_rise[gi]),
            .fall   (pin_fall[gi])
        );
    end

    logic scl_lvl, scl_rise, scl_fall, sda_lvl;
    logic start_cond, stop_cond;

    assign scl_lvl    = pin_lvl[0];
    assign scl_rise   = pin_rise[0];
    assign scl_fall   = pin_fall[0];
    assign sda_lvl    = pin_lvl[1];
    assign start_cond = pin_fall[1] & scl_lvl;
    assign stop_cond  = pin_rise[1] & scl_lvl;

    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       rd_mode_q, rd_mode_d;
    logic [7:0] ptr_q, ptr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_strobe_q, rd_strobe_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_byte;

    assign rx_byte = {shreg_q[6:0], sda_lvl};

    // bit_cnt: 0..7 data bits, 8 = byte done (ACK slot pending), 9 = ACK clock high.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rd_mode_d   = rd_mode_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_strobe_d = 1'b0;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;

        if (stop_cond) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_cond) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_WR_PTR, ST_WR_BYTE: begin
                    if (scl_rise) begin
                        if (bit_cnt_q < 4'd8) begin
                            shreg_d   = rx_byte;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                if (state_q == ST_ADDR) begin
                                    if (addr_match(rx_byte, DEV_ADDR)) begin
                                        state_d   = ST_ADDR_ACK;
                                        rd_mode_d = rx_byte[0];
                                    end else begin
                                        state_d = ST_WAIT_STOP;
                                    end
                                end else if (state_q == ST_WR_PTR) begin
                                    ptr_d = rx_byte;
                                end else begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_data_d = rx_byte;
                                    ptr_d     = ptr_q + 8'd1;
                                end
                            end
                        end else begin
                            bit_cnt_d = 4'd9;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b1;
                        end else if (bit_cnt_q == 4'd9) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_WR_BYTE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd9;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else if (bit_cnt_q == 4'd9) begin
                            bit_cnt_d = 4'd0;
                            if (rd_mode_q) begin
                                shreg_d     = rf.rd_data;
                                rd_strobe_d = 1'b1;
                                sda_oe_d    = ~rf.rd_data[7];
                                state_d     = ST_RD_BYTE;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_WR_PTR;
                            end
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q >= 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    // Pointer advances past the byte just sent whether ACKed or not.
                    if (scl_rise) begin
                        ptr_d = ptr_q + 8'd1;
                        if (sda_lvl == I2C_ACK) begin
                            bit_cnt_d = 4'd9;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        shreg_d     = rf.rd_data;
                        rd_strobe_d = 1'b1;
                        sda_oe_d    = ~rf.rd_data[7];
                        bit_cnt_d   = 4'd0;
                        state_d     = ST_RD_BYTE;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 8'd0;
            rd_mode_q   <= 1'b0;
            ptr_q       <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
            rd_strobe_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rd_mode_q   <= rd_mode_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_strobe_q <= rd_strobe_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign rf.wr_en     = wr_en_q;
    assign rf.wr_addr   = wr_addr_q;
    assign rf.wr_data   = wr_data_q;
    assign rf.rd_addr   = ptr_q;
    assign rf.rd_strobe = rd_strobe_q;
endmodule
